led_progress_ctrl: RTL and testbench

Parametrised LED indicator controller for the reaction-time tester. It drives an N-LED bar from the main game FSM state and the per-player trial counters. Compared with the fixed 8-LED, 2-player driver, it adds a thermometer progress bar, a blinking "waiting" LED, a timed celebration blink on a completed round, and configurable output polarity. It sits between the top-level game FSM and the board LED pins.

---
 rtl/led_pkg.sv | 26 ++
 rtl/blink_divider.sv | 42 ++++
 rtl/led_progress_ctrl.sv | 171 +++++++++++++++++
 tb/tb_led_progress_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// ============================================================================
// Module      : led_pkg
// Description : Shared game-state codes, player indices and LED FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package led_pkg;

  localparam logic [2:0] START   = 3'd3;
  localparam logic [2:0] STORAGE = 3'd4;
  localparam logic [2:0] AVERAGE = 3'd6;

  localparam int PLAYER_A = 1;
  localparam int PLAYER_B = 0;

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_PROG  = 2'd1,
    S_CELEB = 2'd2,
    S_DONE  = 2'd3
  } led_state_t;

endpackage

`default_nettype wire

// File: rtl/blink_divider.sv
// ============================================================================
// Module      : blink_divider
// Description : Free-running half-period counter with restartable blink phase.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module blink_divider #(
  parameter int DIV = 12_500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic phase,
  output logic wrap
);

  localparam int            DW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  logic [DW-1:0] r_div;
  logic          r_phase;

  assign wrap  = (r_div == DIV_LAST);
  assign phase = r_phase;

  // Restart takes priority over a coincident wrap.
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      r_div   <= '0;
      r_phase <= 1'b1;
    end else if (wrap) begin
      r_div   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_div   <= r_div + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/led_progress_ctrl.sv
// ============================================================================
// Module      : led_progress_ctrl
// Description : N-LED progress bar / blink / celebration driver for the game FSM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_progress_ctrl
  import led_pkg::*;
#(
  parameter  int N_LEDS        = 8,
  parameter  int N_PLAYERS     = 2,
  parameter  int ACTIVE_LOW    = 1,
  parameter  int BLINK_DIV     = 12_500_000,
  parameter  int CELEB_TOGGLES = 6,
  localparam int TW            = $clog2(N_LEDS),
  localparam int PW            = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [2:0]                machine_state,
  input  logic [PW-1:0]             cur_player,
  input  logic [N_PLAYERS*TW-1:0]   test_turn_flat,
  output logic [N_LEDS-1:0]         led
);

  localparam logic [TW-1:0]     LAST      = TW'(N_LEDS - 1);
  localparam int                FW        = (CELEB_TOGGLES > 1) ? $clog2(CELEB_TOGGLES + 1) : 1;
  localparam logic [FW-1:0]     FLIP_LAST = FW'((CELEB_TOGGLES > 0) ? CELEB_TOGGLES - 1 : 0);
  localparam logic [N_LEDS-1:0] LED_IDLE  = (ACTIVE_LOW != 0) ? {N_LEDS{1'b1}} : {N_LEDS{1'b0}};

  led_state_t        r_state;
  led_state_t        w_state_nxt;
  logic [PW-1:0]     r_prev_player;
  logic [TW-1:0]     r_prev_turn;
  logic [FW-1:0]     r_flips;
  logic [N_LEDS-1:0] r_led;

  logic [TW-1:0]     w_turn_raw;
  logic [TW-1:0]     w_turn;
  logic              w_is_last;
  logic              w_player_chg;
  logic              w_celeb_restart;
  logic              w_restart;
  logic              w_phase;
  logic              w_wrap;
  logic              w_phase_nxt;
  logic [N_LEDS-1:0] w_lit;

  // Out-of-range player indices match no slice and fall back to player 0.
  always_comb begin
    w_turn_raw = test_turn_flat[TW-1:0];
    for (int p = 1; p < N_PLAYERS; p++) begin
      if (cur_player == PW'(p)) begin
        w_turn_raw = test_turn_flat[p*TW +: TW];
      end
    end
  end

  generate
    if ((1 << TW) > N_LEDS) begin : g_sat
      assign w_turn = (w_turn_raw > LAST) ? LAST : w_turn_raw;
    end else begin : g_nosat
      assign w_turn = w_turn_raw;
    end
  endgenerate

  assign w_is_last    = (w_turn == LAST);
  assign w_player_chg = (cur_player != r_prev_player);

  always_comb begin
    w_state_nxt     = S_OFF;
    w_celeb_restart = 1'b0;
    case (machine_state)
      START, STORAGE: w_state_nxt = S_PROG;
      AVERAGE: begin
        if (w_is_last) begin
          case (r_state)
            S_OFF, S_PROG: begin
              w_state_nxt     = S_CELEB;
              w_celeb_restart = 1'b1;
            end
            S_CELEB: begin
              if (w_player_chg) begin
                w_state_nxt     = S_CELEB;
                w_celeb_restart = 1'b1;
              end else if (w_wrap && (r_flips == FLIP_LAST)) begin
                w_state_nxt = S_DONE;
              end else begin
                w_state_nxt = S_CELEB;
              end
            end
            default: begin
              if (w_player_chg) begin
                w_state_nxt     = S_CELEB;
                w_celeb_restart = 1'b1;
              end else begin
                w_state_nxt = S_DONE;
              end
            end
          endcase
        end
      end
      default: w_state_nxt = S_OFF;
    endcase
  end

  assign w_restart = w_celeb_restart ||
                     ((w_state_nxt == S_PROG) &&
                      ((r_state != S_PROG) || (w_turn != r_prev_turn)));

  blink_divider #(
    .DIV (BLINK_DIV)
  ) u_blink (
    .clk     (clk),
    .rst     (rst),
    .restart (w_restart),
    .phase   (w_phase),
    .wrap    (w_wrap)
  );

  // Pattern is built from next-cycle state so led follows inputs by one clock.
  assign w_phase_nxt = w_restart ? 1'b1 : (w_wrap ? ~w_phase : w_phase);

  always_comb begin
    w_lit = '0;
    case (w_state_nxt)
      S_PROG: begin
        for (int i = 0; i < N_LEDS; i++) begin
          if (machine_state == START) begin
            if (i < int'(w_turn)) begin
              w_lit[i] = 1'b1;
            end else if (i == int'(w_turn)) begin
              w_lit[i] = w_phase_nxt;
            end
          end else if (i <= int'(w_turn)) begin
            w_lit[i] = 1'b1;
          end
        end
      end
      S_CELEB: w_lit = {N_LEDS{w_phase_nxt}};
      S_DONE:  w_lit = {N_LEDS{1'b1}};
      default: w_lit = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_OFF;
      r_prev_player <= '0;
      r_prev_turn   <= '0;
      r_flips       <= '0;
      r_led         <= LED_IDLE;
    end else begin
      r_state       <= w_state_nxt;
      r_prev_player <= cur_player;
      r_prev_turn   <= w_turn;
      if ((w_state_nxt != S_CELEB) || w_celeb_restart) begin
        r_flips <= '0;
      end else if (w_wrap) begin
        r_flips <= r_flips + 1'b1;
      end
      r_led <= (ACTIVE_LOW != 0) ? ~w_lit : w_lit;
    end
  end

  assign led = r_led;

endmodule

`default_nettype wire

// File: tb/tb_led_progress_ctrl.sv
// ============================================================================
// Module      : tb_led_progress_ctrl
// Description : Directed scoreboard bench for led_progress_ctrl (8-, 4- and 5-LED builds).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_progress_ctrl;
  import led_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] ms;
  logic       cp;
  logic [5:0] flat8;
  logic [3:0] flat4;
  logic [5:0] flat5;
  logic [7:0] led8;
  logic [3:0] led4;
  logic [4:0] led5;

  always #5 clk = ~clk;

  led_progress_ctrl #(
    .N_LEDS(8), .N_PLAYERS(2), .ACTIVE_LOW(1), .BLINK_DIV(4), .CELEB_TOGGLES(6)
  ) u_dut8 (
    .clk(clk), .rst(rst), .machine_state(ms), .cur_player(cp),
    .test_turn_flat(flat8), .led(led8)
  );

  led_progress_ctrl #(
    .N_LEDS(4), .N_PLAYERS(2), .ACTIVE_LOW(0), .BLINK_DIV(4), .CELEB_TOGGLES(6)
  ) u_dut4 (
    .clk(clk), .rst(rst), .machine_state(ms), .cur_player(cp),
    .test_turn_flat(flat4), .led(led4)
  );

  led_progress_ctrl #(
    .N_LEDS(5), .N_PLAYERS(2), .ACTIVE_LOW(0), .BLINK_DIV(4), .CELEB_TOGGLES(6)
  ) u_dut5 (
    .clk(clk), .rst(rst), .machine_state(ms), .cur_player(cp),
    .test_turn_flat(flat5), .led(led5)
  );

  typedef struct packed {
    logic [1:0] sel;
    logic [7:0] exp;
  } sb_t;

  sb_t   sbq[$];
  string tagq[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  task automatic expect_led(input logic [1:0] sel, input logic [7:0] e, input string tag);
    sb_t item;
    item.sel = sel;
    item.exp = e;
    sbq.push_back(item);
    tagq.push_back(tag);
  endtask

  // 8-LED build is active-low: the pin value is the inverted lit pattern.
  task automatic exp8(input logic [7:0] lit, input string tag);
    expect_led(2'd0, ~lit, tag);
  endtask

  function automatic logic [7:0] observe(input logic [1:0] sel);
    case (sel)
      2'd0:    return led8;
      2'd1:    return {4'b0000, led4};
      default: return {3'b000, led5};
    endcase
  endfunction

  task automatic tick();
    sb_t        item;
    string      tag;
    logic [7:0] obs;
    @(posedge clk);
    #1;
    while (sbq.size() > 0) begin
      item = sbq.pop_front();
      tag  = tagq.pop_front();
      obs  = observe(item.sel);
      n_tests++;
      assert (obs === item.exp) else begin
        n_fail++;
        $error("FAIL %s: observed %b expected %b", tag, obs, item.exp);
      end
    end
  endtask

  function automatic logic [7:0] celeb_lit(input int k);
    return (((k / 4) % 2) == 0) ? 8'hFF : 8'h00;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst   = 1'b1;
    ms    = 3'd0;
    cp    = 1'b0;
    flat8 = '0;
    flat4 = '0;
    flat5 = '0;

    for (int k = 0; k < 3; k++) begin
      ms    = 3'($urandom_range(0, 7));
      cp    = 1'($urandom_range(0, 1));
      flat8 = 6'($urandom);
      flat4 = 4'($urandom);
      flat5 = 6'($urandom);
      exp8(8'h00, "reset_hold");
      expect_led(2'd1, 8'h00, "reset_hold_al0");
      tick();
    end

    rst = 1'b0;
    ms  = 3'd0;
    exp8(8'h00, "post_reset");
    tick();

    // Solid thermometer, player A then player B
    ms    = STORAGE;
    cp    = 1'(PLAYER_A);
    flat8 = {3'd3, 3'd0};
    for (int k = 0; k < 3; k++) begin
      exp8(8'b0000_1111, "storage_t3");
      tick();
    end
    flat8 = {3'd5, 3'd0};
    exp8(8'b0011_1111, "storage_t5");
    tick();
    cp    = 1'(PLAYER_B);
    flat8 = {3'd5, 3'd1};
    exp8(8'b0000_0011, "storage_playerB_t1");
    tick();

    ms = 3'd0;
    exp8(8'h00, "idle_off");
    tick();

    // Progress with blinking head LED, then a turn change restarts the blink
    ms    = START;
    cp    = 1'(PLAYER_A);
    flat8 = {3'd2, 3'd0};
    for (int k = 0; k < 12; k++) begin
      exp8(8'b0000_0011 | ((((k / 4) % 2) == 0) ? 8'b0000_0100 : 8'b0), "start_t2_blink");
      tick();
    end
    flat8 = {3'd3, 3'd0};
    for (int k = 0; k < 8; k++) begin
      exp8(8'b0000_0111 | ((((k / 4) % 2) == 0) ? 8'b0000_1000 : 8'b0), "start_t3_restart");
      tick();
    end

    ms = 3'd0;
    exp8(8'h00, "idle_off2");
    tick();

    // Full celebration then solid bar
    ms    = AVERAGE;
    cp    = 1'(PLAYER_A);
    flat8 = {3'd7, 3'd0};
    for (int k = 0; k < 24; k++) begin
      exp8(celeb_lit(k), "celeb_blink");
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      exp8(8'hFF, "celeb_done");
      tick();
    end
    flat8 = {3'd6, 3'd0};
    exp8(8'h00, "average_not_last");
    tick();

    // Player switch mid-celebration restarts the full sequence
    flat8 = {3'd7, 3'd7};
    for (int k = 0; k < 10; k++) begin
      exp8(celeb_lit(k), "celeb_A_partial");
      tick();
    end
    cp = 1'(PLAYER_B);
    for (int k = 0; k < 24; k++) begin
      exp8(celeb_lit(k), "celeb_B_restart");
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      exp8(8'hFF, "celeb_B_done");
      tick();
    end
    cp = 1'(PLAYER_A);
    for (int k = 0; k < 5; k++) begin
      exp8(celeb_lit(k), "done_switch_restart");
      tick();
    end
    flat8 = {3'd7, 3'd4};
    cp    = 1'(PLAYER_B);
    exp8(8'h00, "celeb_switch_B_t4");
    tick();

    // Reset during a celebration leaves no residue
    cp    = 1'(PLAYER_A);
    flat8 = {3'd7, 3'd0};
    for (int k = 0; k < 6; k++) begin
      exp8(celeb_lit(k), "celeb_pre_reset");
      tick();
    end
    rst = 1'b1;
    exp8(8'h00, "reset_mid_celeb");
    tick();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      exp8(celeb_lit(k), "celeb_after_reset");
      tick();
    end

    // Active-high builds: 4-LED and saturating 5-LED
    ms    = STORAGE;
    cp    = 1'(PLAYER_A);
    flat4 = {2'd1, 2'd0};
    flat5 = {3'd2, 3'd0};
    expect_led(2'd1, 8'b0000_0011, "al0_n4_t1");
    expect_led(2'd2, 8'b0000_0111, "al0_n5_t2");
    tick();
    flat4 = {2'd3, 2'd0};
    flat5 = {3'd7, 3'd0};
    expect_led(2'd1, 8'b0000_1111, "al0_n4_t3");
    expect_led(2'd2, 8'b0001_1111, "al0_n5_sat7");
    tick();
    cp    = 1'(PLAYER_B);
    flat5 = {3'd0, 3'd5};
    expect_led(2'd2, 8'b0001_1111, "al0_n5_playerB_sat5");
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
